// File: rtl/harm_power_accum.sv
// harm_power_accum: per-frame harmonic power accumulator with fundamental capture
module harm_power_accum #(
  parameter int W        = 24,
  parameter int IDX_W    = 6,
  parameter int MAX_HARM = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bin_valid,
  output logic                    bin_ready,
  input  logic [IDX_W-1:0]        bin_idx,
  input  logic signed [W-1:0]     bin_re,
  input  logic signed [W-1:0]     bin_im,
  input  logic                    bin_last,
  output logic [47:0]             sum,
  output logic signed [W-1:0]     a,
  output logic signed [W-1:0]     b,
  output logic                    out_valid,
  output logic                    ovf,
  output logic                    no_fund
);
  typedef enum logic [1:0] {ACC, DRAIN, PUB} state_t;
  state_t state_q, state_d;
  logic accept, pub, harm, fund_hit;
  logic signed [2*W-1:0] p_re, p_im;
  logic [48:0] acc_add;
  logic [47:0] sq_d, sq_q, acc_d, acc_q, sum_d, sum_q;
  logic signed [W-1:0] fund_re_d, fund_re_q, fund_im_d, fund_im_q, a_d, a_q, b_d, b_q;
  logic sqv_d, sqv_q, ovf_acc_d, ovf_acc_q, fund_seen_d, fund_seen_q;
  logic ovf_d, ovf_q, no_fund_d, no_fund_q, out_valid_d, out_valid_q;
  assign bin_ready = state_q == ACC;
  assign accept    = bin_valid && bin_ready;
  assign pub       = state_q == PUB;
  assign sum       = sum_q;
  assign a         = a_q;
  assign b         = b_q;
  assign ovf       = ovf_q;
  assign no_fund   = no_fund_q;
  assign out_valid = out_valid_q;
  // frame sequencing: two bubble cycles after the last beat, publishing in the second
  always_comb begin
    state_d = state_q == ACC ? ((accept && bin_last) ? DRAIN : ACC) : state_q == DRAIN ? PUB : ACC;
  end
  // squaring stage, saturating accumulate, fundamental capture and publish
  always_comb begin
    p_re        = (2*W)'(bin_re) * (2*W)'(bin_re);
    p_im        = (2*W)'(bin_im) * (2*W)'(bin_im);
    sq_d        = 48'($unsigned(p_re)) + 48'($unsigned(p_im));
    harm        = bin_idx >= IDX_W'(2) && bin_idx <= IDX_W'(MAX_HARM);
    sqv_d       = accept && harm;
    fund_hit    = accept && bin_idx == IDX_W'(1);
    acc_add     = {1'b0, acc_q} + {1'b0, sq_q};
    acc_d       = pub ? '0 : !sqv_q ? acc_q : acc_add[48] ? '1 : acc_add[47:0];
    ovf_acc_d   = pub ? 1'b0 : ovf_acc_q | (sqv_q & acc_add[48]);
    fund_re_d   = pub ? '0 : fund_hit ? bin_re : fund_re_q;
    fund_im_d   = pub ? '0 : fund_hit ? bin_im : fund_im_q;
    fund_seen_d = pub ? 1'b0 : fund_seen_q | fund_hit;
    sum_d       = pub ? acc_q : sum_q;
    a_d         = pub ? (fund_seen_q ? fund_re_q : '0) : a_q;
    b_d         = pub ? (fund_seen_q ? fund_im_q : '0) : b_q;
    ovf_d       = pub ? ovf_acc_q : ovf_q;
    no_fund_d   = pub ? !fund_seen_q : no_fund_q;
    out_valid_d = pub;
  end
  // state and datapath registers; reset discards any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      sq_q        <= '0;
      sqv_q       <= 1'b0;
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      fund_re_q   <= '0;
      fund_im_q   <= '0;
      fund_seen_q <= 1'b0;
      sum_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ovf_q       <= 1'b0;
      no_fund_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sq_q        <= sq_d;
      sqv_q       <= sqv_d;
      acc_q       <= acc_d;
      ovf_acc_q   <= ovf_acc_d;
      fund_re_q   <= fund_re_d;
      fund_im_q   <= fund_im_d;
      fund_seen_q <= fund_seen_d;
      sum_q       <= sum_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ovf_q       <= ovf_d;
      no_fund_q   <= no_fund_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_harm_power_accum.sv
// tb_harm_power_accum: table-driven and randomized checks of harm_power_accum (MAX_HARM 15 and 3)
module tb_harm_power_accum;
  localparam int W  = 24;
  localparam int IW = 6;
  logic clk = 1'b0;
  logic rst, bin_valid, bin_last;
  logic [IW-1:0] bin_idx;
  logic signed [W-1:0] bin_re, bin_im;
  logic r15, r3, v15, v3, o15, o3, n15, n3;
  logic [47:0] s15, s3;
  logic [W-1:0] a15, b15, a3, b3;
  typedef struct { logic [IW-1:0] idx; logic signed [W-1:0] re, im; } beat_t;
  typedef struct { logic [47:0] sum; logic [W-1:0] a, b; logic ovf, nf; } exp_t;
  typedef struct { int n; beat_t bt[5]; exp_t e15, e3; } vec_t;
  int errors = 0, checks = 0, pulses = 0, exp_pulses = 0;
  beat_t frm[$];
  vec_t v[5];

  always #5 clk = ~clk;

  harm_power_accum #(.W(W), .IDX_W(IW), .MAX_HARM(15)) dut15 (
    .clk(clk), .rst(rst), .bin_valid(bin_valid), .bin_ready(r15), .bin_idx(bin_idx),
    .bin_re(bin_re), .bin_im(bin_im), .bin_last(bin_last), .sum(s15), .a(a15), .b(b15),
    .out_valid(v15), .ovf(o15), .no_fund(n15));
  harm_power_accum #(.W(W), .IDX_W(IW), .MAX_HARM(3)) dut3 (
    .clk(clk), .rst(rst), .bin_valid(bin_valid), .bin_ready(r3), .bin_idx(bin_idx),
    .bin_re(bin_re), .bin_im(bin_im), .bin_last(bin_last), .sum(s3), .a(a3), .b(b3),
    .out_valid(v3), .ovf(o3), .no_fund(n3));

  always @(negedge clk) pulses = pulses + int'(v15) + int'(v3);

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic beat_t mk(input int idx, input int re, input int im);
    beat_t t;
    t.idx = IW'(idx);
    t.re  = W'(re);
    t.im  = W'(im);
    return t;
  endfunction

  function automatic logic signed [W-1:0] rnd();
    int k = $urandom_range(0, 4);
    return k == 0 ? 24'h800000 : k == 1 ? 24'h7FFFFF : W'($urandom);
  endfunction

  // reference: sum of squares over harmonic bins with clamp, last bin-1 beat wins
  function automatic exp_t model(input int maxh);
    exp_t e;
    longint s = 0;
    longint mx = 64'hFFFF_FFFF_FFFF;
    e.sum = '0; e.a = '0; e.b = '0; e.ovf = 1'b0; e.nf = 1'b1;
    foreach (frm[i]) begin
      longint r = frm[i].re;
      longint m = frm[i].im;
      if (frm[i].idx >= 2 && frm[i].idx <= maxh) begin
        s = s + r * r + m * m;
        if (s > mx) begin
          s = mx;
          e.ovf = 1'b1;
        end
      end
      if (frm[i].idx == 1) begin
        e.a = frm[i].re;
        e.b = frm[i].im;
        e.nf = 1'b0;
      end
    end
    e.sum = s[47:0];
    return e;
  endfunction

  task automatic put(input beat_t bt, input bit last);
    bit r = 1'b0;
    int n = 0;
    bin_valid = 1'b1;
    bin_idx = bt.idx;
    bin_re = bt.re;
    bin_im = bt.im;
    bin_last = last;
    while (!r && n < 50) begin
      @(negedge clk);
      r = r15 && r3;
      @(posedge clk);
      #1;
      n++;
    end
    if (!r) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got=no_ready exp=ready");
    end
    bin_valid = 1'b0;
    bin_last = 1'b0;
  endtask

  task automatic send_frame(input int gap_max, input bit with_last);
    foreach (frm[i]) begin
      repeat ($urandom_range(gap_max, 0)) begin
        @(posedge clk);
        #1;
      end
      put(frm[i], with_last && i == frm.size() - 1);
    end
  endtask

  task automatic check_pub(input exp_t e15, input exp_t e3);
    @(negedge clk);
    chk("ready_T1_15", 64'(r15), 0); chk("ready_T1_3", 64'(r3), 0); chk("ov_T1", 64'(v15 | v3), 0);
    @(negedge clk);
    chk("ready_T2_15", 64'(r15), 0); chk("ready_T2_3", 64'(r3), 0); chk("ov_T2", 64'(v15 | v3), 0);
    @(negedge clk);
    chk("ov_pub_15", 64'(v15), 1); chk("ov_pub_3", 64'(v3), 1); chk("ready_pub", 64'(r15 & r3), 1);
    chk("sum_15", 64'(s15), 64'(e15.sum)); chk("a_15", 64'(a15), 64'(e15.a)); chk("b_15", 64'(b15), 64'(e15.b));
    chk("ovf_15", 64'(o15), 64'(e15.ovf)); chk("nofund_15", 64'(n15), 64'(e15.nf));
    chk("sum_3", 64'(s3), 64'(e3.sum)); chk("a_3", 64'(a3), 64'(e3.a)); chk("b_3", 64'(b3), 64'(e3.b));
    chk("ovf_3", 64'(o3), 64'(e3.ovf)); chk("nofund_3", 64'(n3), 64'(e3.nf));
    exp_pulses += 2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    v[0].n = 5;
    v[0].bt[0] = mk(0, 100, 0); v[0].bt[1] = mk(1, 1000, -2000); v[0].bt[2] = mk(2, 30, 40);
    v[0].bt[3] = mk(3, -5, 12); v[0].bt[4] = mk(4, 0, 0);
    v[0].e15 = '{48'd2669, 24'd1000, 24'hFFF830, 1'b0, 1'b0};
    v[0].e3  = '{48'd2669, 24'd1000, 24'hFFF830, 1'b0, 1'b0};
    v[1].n = 4;
    v[1].bt[0] = mk(1, 7, 7); v[1].bt[1] = mk(2, 3, 4); v[1].bt[2] = mk(4, 100, 0); v[1].bt[3] = mk(0, 9, 9);
    v[1].e15 = '{48'd10025, 24'd7, 24'd7, 1'b0, 1'b0};
    v[1].e3  = '{48'd25, 24'd7, 24'd7, 1'b0, 1'b0};
    v[2].n = 2;
    v[2].bt[0] = mk(2, -8388608, -8388608); v[2].bt[1] = mk(3, -8388608, -8388608);
    v[2].e15 = '{48'hFFFF_FFFF_FFFF, 24'd0, 24'd0, 1'b1, 1'b1};
    v[2].e3  = '{48'hFFFF_FFFF_FFFF, 24'd0, 24'd0, 1'b1, 1'b1};
    v[3].n = 1;
    v[3].bt[0] = mk(2, 1, 1);
    v[3].e15 = '{48'd2, 24'd0, 24'd0, 1'b0, 1'b1};
    v[3].e3  = '{48'd2, 24'd0, 24'd0, 1'b0, 1'b1};
    v[4].n = 2;
    v[4].bt[0] = mk(1, 10, 20); v[4].bt[1] = mk(1, -3, 4);
    v[4].e15 = '{48'd0, 24'hFFFFFD, 24'd4, 1'b0, 1'b0};
    v[4].e3  = '{48'd0, 24'hFFFFFD, 24'd4, 1'b0, 1'b0};

    rst = 1'b1; bin_valid = 1'b0; bin_last = 1'b0; bin_idx = '0; bin_re = '0; bin_im = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_sum", 64'(s15 | s3), 0); chk("rst_a", 64'(a15 | a3), 0); chk("rst_b", 64'(b15 | b3), 0);
    chk("rst_ov", 64'(v15 | v3), 0); chk("rst_ovf", 64'(o15 | o3), 0); chk("rst_nf", 64'(n15 | n3), 0);
    chk("rst_ready", 64'(r15 & r3), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 5; k++) begin
        frm.delete();
        for (int j = 0; j < v[k].n; j++) frm.push_back(v[k].bt[j]);
        send_frame(p == 0 ? 0 : 2, 1'b1);
        check_pub(v[k].e15, v[k].e3);
      end

    frm.delete();
    frm.push_back(mk(2, 30, 40)); frm.push_back(mk(1, 11, -11));
    send_frame(0, 1'b1);
    bin_valid = 1'b1; bin_idx = 6'd2; bin_re = 24'sd6; bin_im = 24'sd8; bin_last = 1'b1;
    check_pub('{48'd2500, 24'd11, 24'hFFFFF5, 1'b0, 1'b0}, '{48'd2500, 24'd11, 24'hFFFFF5, 1'b0, 1'b0});
    bin_valid = 1'b0; bin_last = 1'b0;
    check_pub('{48'd100, 24'd0, 24'd0, 1'b0, 1'b1}, '{48'd100, 24'd0, 24'd0, 1'b0, 1'b1});

    frm.delete();
    frm.push_back(mk(1, 5, 5)); frm.push_back(mk(2, 3, 4));
    send_frame(0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    frm.delete();
    frm.push_back(mk(2, 6, 8));
    send_frame(0, 1'b1);
    check_pub('{48'd100, 24'd0, 24'd0, 1'b0, 1'b1}, '{48'd100, 24'd0, 24'd0, 1'b0, 1'b1});

    repeat (40) begin
      frm.delete();
      repeat ($urandom_range(1, 8)) frm.push_back(mk($urandom_range(0, 20), int'(rnd()), int'(rnd())));
      send_frame(2, 1'b1);
      check_pub(model(15), model(3));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pulse_count", 64'(pulses), 64'(exp_pulses));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
